stream_fifo_thresh: RTL and testbench

Parametrised ready/valid FIFO and the successor to the legacy push/grant FIFO wrapper. Adds a generic data width and depth, an optional fall-through mode, a fill-level output, programmable almost-full/almost-empty thresholds and a synchronous flush. It sits between stream producers and consumers in the common-cells library and is the default buffering primitive for new blocks.

---
 rtl/stream_fifo_pkg.sv | 13 +
 rtl/fifo_ptr_ctrl.sv | 59 +++++
 rtl/stream_fifo_thresh.sv | 106 ++++++++++
 tb/tb_stream_fifo_thresh.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_fifo_pkg.sv
// Shared types, constants and helpers for the stream_fifo_thresh FIFO.
package stream_fifo_pkg;

  typedef logic [31:0] stall_cnt_t;

  localparam stall_cnt_t STALL_CNT_MAX = 32'hFFFF_FFFF;

  // Pointer width for a given depth. Never narrower than one bit.
  function automatic int fifo_ptr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// Read/write pointers, usage counter and full/empty for stream_fifo_thresh.
// Pointers wrap explicitly at Depth-1, so non-power-of-two depths work.
module fifo_ptr_ctrl
  import stream_fifo_pkg::*;
#(
  parameter int Depth = 8,
  parameter int PtrW  = fifo_ptr_w(Depth),
  parameter int UsgW  = $clog2(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            push_i,
  input  logic            pop_i,
  output logic [PtrW-1:0] wr_ptr_o,
  output logic [PtrW-1:0] rd_ptr_o,
  output logic [UsgW-1:0] usage_o,
  output logic            full_o,
  output logic            empty_o
);

  logic [PtrW-1:0] r_wr_ptr, r_rd_ptr;
  logic [UsgW-1:0] r_usage;
  logic [PtrW-1:0] w_wr_nxt, w_rd_nxt;

  // Next pointer values with explicit wrap from Depth-1 to 0.
  always_comb begin
    w_wr_nxt = (r_wr_ptr == PtrW'(Depth - 1)) ? '0 : r_wr_ptr + 1'b1;
    w_rd_nxt = (r_rd_ptr == PtrW'(Depth - 1)) ? '0 : r_rd_ptr + 1'b1;
  end

  // Pointer and usage update; flush wins over any handshake.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_usage  <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_usage  <= '0;
    end else begin
      if (push_i) r_wr_ptr <= w_wr_nxt;
      if (pop_i)  r_rd_ptr <= w_rd_nxt;
      case ({push_i, pop_i})
        2'b10:   r_usage <= r_usage + 1'b1;
        2'b01:   r_usage <= r_usage - 1'b1;
        default: r_usage <= r_usage;
      endcase
    end
  end

  assign wr_ptr_o = r_wr_ptr;
  assign rd_ptr_o = r_rd_ptr;
  assign usage_o  = r_usage;
  assign full_o   = (r_usage == UsgW'(Depth));
  assign empty_o  = (r_usage == '0);

endmodule

// File: rtl/stream_fifo_thresh.sv
// Ready/valid FIFO with optional fall-through, fill level, almost-full /
// almost-empty thresholds and synchronous flush.
// Optional stall counters: define STREAM_FIFO_THRESH_STALL_CNT_EN.
module stream_fifo_thresh
  import stream_fifo_pkg::*;
#(
  parameter int DataWidth      = 32,
  parameter int Depth          = 8,
  parameter bit FallThrough    = 1'b0,
  parameter int AlmFullThresh  = 6,
  parameter int AlmEmptyThresh = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       testmode_i,
  input  logic                       valid_i,
  output logic                       ready_o,
  input  logic [DataWidth-1:0]       data_i,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [DataWidth-1:0]       data_o,
  output logic [$clog2(Depth+1)-1:0] usage_o,
  output logic                       alm_full_o,
  output logic                       alm_empty_o,
  output logic [31:0]                stall_in_cnt_o,
  output logic [31:0]                stall_out_cnt_o
);

  localparam int PtrW = fifo_ptr_w(Depth);
  localparam int UsgW = $clog2(Depth + 1);

  logic [DataWidth-1:0] r_mem [Depth];
  logic [PtrW-1:0]      w_wr_ptr, w_rd_ptr;
  logic [UsgW-1:0]      w_usage;
  logic                 w_full, w_empty;
  logic                 w_ft, w_push, w_pop;
  logic                 w_unused;

  // Clock-gate bypass hook only; nothing functional depends on it.
  assign w_unused = testmode_i;

  fifo_ptr_ctrl #(.Depth(Depth), .PtrW(PtrW), .UsgW(UsgW)) u_ptr_ctrl (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .flush_i  (flush_i),
    .push_i   (w_push),
    .pop_i    (w_pop),
    .wr_ptr_o (w_wr_ptr),
    .rd_ptr_o (w_rd_ptr),
    .usage_o  (w_usage),
    .full_o   (w_full),
    .empty_o  (w_empty)
  );

  // Handshakes. A fall-through word that is consumed at once bypasses
  // storage; if the consumer stalls it is stored like any other push.
  always_comb begin
    w_ft    = FallThrough && w_empty && valid_i && !flush_i;
    ready_o = !w_full && !flush_i;
    valid_o = (!w_empty || w_ft) && !flush_i;
    data_o  = w_ft ? data_i : r_mem[w_rd_ptr];
    w_push  = valid_i && ready_o && !(w_ft && ready_i);
    w_pop   = valid_o && ready_i && !w_ft;
  end

  // Storage; contents survive a flush, only the pointers are cleared.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[w_wr_ptr] <= data_i;
    end
  end

  assign usage_o     = w_usage;
  assign alm_full_o  = (w_usage >= UsgW'(AlmFullThresh));
  assign alm_empty_o = (w_usage <= UsgW'(AlmEmptyThresh));

`ifdef STREAM_FIFO_THRESH_STALL_CNT_EN
  stall_cnt_t r_stall_in, r_stall_out;

  // Saturating stall counters, cleared by flush (no counting in that cycle).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_stall_in  <= '0;
      r_stall_out <= '0;
    end else if (flush_i) begin
      r_stall_in  <= '0;
      r_stall_out <= '0;
    end else begin
      if (valid_i && !ready_o && r_stall_in != STALL_CNT_MAX)
        r_stall_in <= r_stall_in + 1'b1;
      if (!valid_o && ready_i && r_stall_out != STALL_CNT_MAX)
        r_stall_out <= r_stall_out + 1'b1;
    end
  end

  assign stall_in_cnt_o  = r_stall_in;
  assign stall_out_cnt_o = r_stall_out;
`else
  assign stall_in_cnt_o  = '0;
  assign stall_out_cnt_o = '0;
`endif

endmodule

// File: tb/tb_stream_fifo_thresh.sv
// Directed bench for stream_fifo_thresh: default config, Depth=5 wrap
// config and a fall-through config share one set of stimulus inputs.
module tb_stream_fifo_thresh;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        valid = 1'b0;
  logic        ready = 1'b0;
  logic [31:0] data  = '0;

  logic        d_rdy, d_vld, d_af, d_ae;
  logic [31:0] d_dat, d_sin, d_sout;
  logic [3:0]  d_usg;

  logic        w_rdy, w_vld, w_af, w_ae;
  logic [31:0] w_dat, w_sin, w_sout;
  logic [2:0]  w_usg;

  logic        f_rdy, f_vld, f_af, f_ae;
  logic [31:0] f_dat, f_sin, f_sout;
  logic [3:0]  f_usg;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stream_fifo_thresh u_def (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .testmode_i(1'b0),
    .valid_i(valid), .ready_o(d_rdy), .data_i(data),
    .valid_o(d_vld), .ready_i(ready), .data_o(d_dat),
    .usage_o(d_usg), .alm_full_o(d_af), .alm_empty_o(d_ae),
    .stall_in_cnt_o(d_sin), .stall_out_cnt_o(d_sout)
  );

  stream_fifo_thresh #(.Depth(5), .AlmFullThresh(4), .AlmEmptyThresh(1)) u_d5 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .testmode_i(1'b0),
    .valid_i(valid), .ready_o(w_rdy), .data_i(data),
    .valid_o(w_vld), .ready_i(ready), .data_o(w_dat),
    .usage_o(w_usg), .alm_full_o(w_af), .alm_empty_o(w_ae),
    .stall_in_cnt_o(w_sin), .stall_out_cnt_o(w_sout)
  );

  stream_fifo_thresh #(.FallThrough(1'b1)) u_ft (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .testmode_i(1'b0),
    .valid_i(valid), .ready_o(f_rdy), .data_i(data),
    .valid_o(f_vld), .ready_i(ready), .data_o(f_dat),
    .usage_o(f_usg), .alm_full_o(f_af), .alm_empty_o(f_ae),
    .stall_in_cnt_o(f_sin), .stall_out_cnt_o(f_sout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    valid = 1'b0; ready = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({d_vld, d_rdy, d_dat, d_usg, d_ae, d_af} !== {1'b0, 1'b1, 32'h0, 4'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs: got vld=%b rdy=%b dat=%h usg=%0d ae=%b af=%b, want 0 1 0 0 1 0",
               d_vld, d_rdy, d_dat, d_usg, d_ae, d_af);
    end
    checks++;
    if ({d_sin, d_sout} !== 64'h0) begin
      errors++;
      $display("FAIL reset_stall_cnt: got in=%0d out=%0d, want 0 0", d_sin, d_sout);
    end
    #2 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fill_drain();
    do_flush();
    ready = 1'b0; valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      data = 32'h11 + i;
      #1;
      checks++;
      if (d_rdy !== 1'b1) begin
        errors++; $display("FAIL fill_ready[%0d]: got %b want 1", i, d_rdy);
      end
      tick();
      checks++;
      if (d_usg !== 4'(i + 1) || d_af !== ((i + 1) >= 6)) begin
        errors++;
        $display("FAIL fill_usage[%0d]: got usg=%0d af=%b want usg=%0d af=%b",
                 i, d_usg, d_af, i + 1, (i + 1) >= 6);
      end
    end
    checks++;
    if (d_rdy !== 1'b0) begin
      errors++; $display("FAIL full_ready: got %b want 0", d_rdy);
    end
    valid = 1'b0; ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++;
      if (d_vld !== 1'b1 || d_dat !== 32'h11 + i || d_ae !== ((8 - i) <= 2)) begin
        errors++;
        $display("FAIL drain[%0d]: got vld=%b dat=%h ae=%b want 1 %h %b",
                 i, d_vld, d_dat, d_ae, 32'h11 + i, (8 - i) <= 2);
      end
      tick();
    end
    checks++;
    if (d_vld !== 1'b0 || d_usg !== 4'd0 || d_ae !== 1'b1) begin
      errors++;
      $display("FAIL drained: got vld=%b usg=%0d ae=%b want 0 0 1", d_vld, d_usg, d_ae);
    end
    ready = 1'b0;
  endtask

  task automatic test_full_push_pop();
    do_flush();
    valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      data = 32'h21 + i;
      tick();
    end
    data = 32'h99; ready = 1'b1;
    #1;
    checks++;
    if (d_rdy !== 1'b0 || d_vld !== 1'b1 || d_dat !== 32'h21) begin
      errors++;
      $display("FAIL full_pushpop_comb: got rdy=%b vld=%b dat=%h want 0 1 21", d_rdy, d_vld, d_dat);
    end
    tick();
    valid = 1'b0; ready = 1'b0;
    #1;
    checks++;
    if (d_usg !== 4'd7 || d_dat !== 32'h22 || d_rdy !== 1'b1) begin
      errors++;
      $display("FAIL full_pushpop_after: got usg=%0d dat=%h rdy=%b want 7 22 1", d_usg, d_dat, d_rdy);
    end
  endtask

  task automatic test_flush();
    do_flush();
    valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data = 32'h31 + i;
      tick();
    end
    data = 32'h55; flush = 1'b1;
    #1;
    checks++;
    if (d_usg !== 4'd4 || d_rdy !== 1'b0 || d_vld !== 1'b0) begin
      errors++;
      $display("FAIL flush_cycle: got usg=%0d rdy=%b vld=%b want 4 0 0", d_usg, d_rdy, d_vld);
    end
    tick();
    flush = 1'b0; valid = 1'b0;
    #1;
    checks++;
    if (d_usg !== 4'd0 || d_vld !== 1'b0 || d_rdy !== 1'b1) begin
      errors++;
      $display("FAIL flush_after: got usg=%0d vld=%b rdy=%b want 0 0 1", d_usg, d_vld, d_rdy);
    end
    valid = 1'b1; data = 32'h66;
    tick();
    valid = 1'b0;
    #1;
    checks++;
    if (d_vld !== 1'b1 || d_dat !== 32'h66 || d_usg !== 4'd1) begin
      errors++;
      $display("FAIL flush_next_push: got vld=%b dat=%h usg=%0d want 1 66 1", d_vld, d_dat, d_usg);
    end
  endtask

  task automatic test_fall_through();
    do_flush();
    valid = 1'b1; data = 32'hAB; ready = 1'b1;
    #1;
    checks++;
    if (f_vld !== 1'b1 || f_dat !== 32'hAB) begin
      errors++; $display("FAIL ft_pass_comb: got vld=%b dat=%h want 1 ab", f_vld, f_dat);
    end
    checks++;
    if (d_vld !== 1'b0) begin
      errors++; $display("FAIL noft_empty_valid: got vld=%b want 0", d_vld);
    end
    tick();
    checks++;
    if (f_usg !== 4'd0) begin
      errors++; $display("FAIL ft_pass_usage: got %0d want 0", f_usg);
    end
    ready = 1'b0; data = 32'hCD;
    #1;
    checks++;
    if (f_vld !== 1'b1 || f_dat !== 32'hCD) begin
      errors++; $display("FAIL ft_stall_comb: got vld=%b dat=%h want 1 cd", f_vld, f_dat);
    end
    tick();
    valid = 1'b0; data = 32'hEE;
    #1;
    checks++;
    if (f_usg !== 4'd1 || f_vld !== 1'b1 || f_dat !== 32'hCD) begin
      errors++;
      $display("FAIL ft_stored: got usg=%0d vld=%b dat=%h want 1 1 cd", f_usg, f_vld, f_dat);
    end
  endtask

  task automatic test_wrap_depth5();
    int sent, recv, over, bad;
    logic fire;
    sent = 0; recv = 0; over = 0; bad = 0;
    do_flush();
    for (int cyc = 0; cyc < 400 && recv < 20; cyc++) begin
      valid = (sent < 20) ? 1'($urandom_range(0, 1)) : 1'b0;
      data  = 32'h40 + sent;
      ready = 1'($urandom_range(0, 1));
      #1;
      if (w_usg > 3'd5) over++;
      if (w_usg == 3'd5 && w_rdy !== 1'b0) over++;
      fire = valid && w_rdy;
      if (w_vld && ready) begin
        if (w_dat !== 32'h40 + recv) begin
          bad++;
          $display("FAIL wrap_data[%0d]: got %h want %h", recv, w_dat, 32'h40 + recv);
        end
        recv++;
      end
      tick();
      if (fire) sent++;
    end
    valid = 1'b0; ready = 1'b0;
    checks++;
    if (recv !== 20) begin
      errors++; $display("FAIL wrap_timeout: got %0d words want 20", recv);
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL wrap_order: got %0d bad words want 0", bad);
    end
    checks++;
    if (over !== 0) begin
      errors++; $display("FAIL wrap_usage_bound: got %0d violations want 0", over);
    end
    checks++;
    if (w_usg !== 3'd0 || w_ae !== 1'b1) begin
      errors++; $display("FAIL wrap_end: got usg=%0d ae=%b want 0 1", w_usg, w_ae);
    end
  endtask

  task automatic test_stall_cnt();
`ifdef STREAM_FIFO_THRESH_STALL_CNT_EN
    do_flush();
    valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      data = 32'h70 + i;
      tick();
    end
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (d_sin !== 32'd10 || d_sout !== 32'd0) begin
      errors++; $display("FAIL stall_in_count: got in=%0d out=%0d want 10 0", d_sin, d_sout);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0; valid = 1'b0;
    #1;
    checks++;
    if (d_sin !== 32'd0) begin
      errors++; $display("FAIL stall_flush: got %0d want 0", d_sin);
    end
    ready = 1'b1;
    tick(); tick(); tick();
    ready = 1'b0;
    checks++;
    if (d_sout !== 32'd3) begin
      errors++; $display("FAIL stall_out_count: got %0d want 3", d_sout);
    end
`else
    valid = 1'b1; ready = 1'b1;
    tick(); tick();
    valid = 1'b0; ready = 1'b0;
    checks++;
    if ({d_sin, d_sout} !== 64'h0) begin
      errors++; $display("FAIL stall_tied_off: got in=%0d out=%0d want 0 0", d_sin, d_sout);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_full_push_pop();
    test_flush();
    test_fall_through();
    test_wrap_depth5();
    test_stall_cnt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
